// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares one single-port frame-buffer SRAM between the scan-out reader and
// the draw-engine writer. Reads normally win. A wait counter forces a write
// slot after MAX_WAIT-1 refused cycles. Writes outside the frame are accepted
// on the handshake and then discarded, and each one is counted. Read data comes
// back two cycles after the grant, in request order.
module fb_port_arbiter #(
  parameter int ADDR_W   = 21,
  parameter int DATA_W   = 8,
  parameter int FB_SIZE  = 307200,
  parameter int MAX_WAIT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic [15:0]       wr_drop_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WC_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WC_W-1:0]   WC_MAX = WC_W'(MAX_WAIT - 1);
  // One extra bit so the limit still fits when FB_SIZE == 2**ADDR_W.
  localparam logic [ADDR_W:0]   FB_LIM = (ADDR_W + 1)'(FB_SIZE);

  logic [WC_W-1:0]   r_wait_cnt;
  logic              r_rd_p1;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [15:0]       r_drop_cnt;

  logic w_wr_urgent;
  logic w_rd_gnt;
  logic w_wr_gnt;
  logic w_wr_in_range;

  // Arbitration on current inputs. Reset suppresses both grants.
  always_comb begin
    w_wr_urgent   = wr_req && (r_wait_cnt == WC_MAX);
    w_rd_gnt      = !Reset && rd_req && !w_wr_urgent;
    w_wr_gnt      = !Reset && wr_req && (w_wr_urgent || !rd_req);
    w_wr_in_range = ({1'b0, wr_addr} < FB_LIM);
  end

  // Count consecutive refused cycles of a pending write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wait_cnt <= '0;
    end else if (!wr_req || w_wr_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WC_MAX) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Drive the SRAM port. The address holds on idle cycles and on dropped writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else if (w_rd_gnt) begin
      r_mem_addr  <= rd_addr;
      r_mem_we    <= 1'b0;
    end else if (w_wr_gnt && w_wr_in_range) begin
      r_mem_addr  <= wr_addr;
      r_mem_wdata <= wr_data;
      r_mem_we    <= 1'b1;
    end else begin
      r_mem_we    <= 1'b0;
    end
  end

  // Two-stage read-return pipeline. A reset flushes any read still in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd_p1    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_p1    <= w_rd_gnt;
      r_rd_valid <= r_rd_p1;
      if (r_rd_p1) begin
        r_rd_data <= mem_rdata;
      end
    end
  end

  // Saturating count of granted writes that fall outside the frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_drop_cnt <= '0;
    end else if (w_wr_gnt && !w_wr_in_range && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign rd_gnt      = w_rd_gnt;
  assign wr_gnt      = w_wr_gnt;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign wr_drop_cnt = r_drop_cnt;
  assign mem_addr    = r_mem_addr;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Testbench for fb_port_arbiter. A small SRAM model is attached to the DUT. A
// reference memory predicts the read data. Each read grant queues the expected
// byte and the cycle it should return, and a monitor pops and checks each
// returned byte.
module tb_fb_port_arbiter;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_gnt;
  logic [15:0]       wr_drop_cnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_SIZE(307200), .MAX_WAIT(16)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .wr_drop_cnt(wr_drop_cnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  // SRAM model: synchronous write, with read data valid in the cycle the address is presented.
  logic [7:0] sram [0:4095];
  always @(posedge Clk) if (mem_we) sram[mem_addr[11:0]] <= mem_wdata;
  assign mem_rdata = sram[mem_addr[11:0]];

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [0:4095];
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       g_rd, g_wr;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample grants mid-cycle, update the model, return just after the edge.
  task automatic tick();
    @(negedge Clk);
    g_rd = rd_gnt;
    g_wr = wr_gnt;
    if (g_rd) sb.push_back('{ref_mem[rd_addr[11:0]], cyc + 2});
    if (g_wr && (wr_addr < 21'd307200)) ref_mem[wr_addr[11:0]] = wr_data;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bit done;
    done = 1'b0;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int k = 0; k < 50 && !done; k++) begin
      tick();
      if (g_wr) done = 1'b1;
    end
    wr_req = 1'b0;
    if (!done) chk("wr_timeout", 32'(done), 32'd1);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    bit done;
    done = 1'b0;
    rd_req = 1'b1; rd_addr = a;
    for (int k = 0; k < 50 && !done; k++) begin
      tick();
      if (g_rd) done = 1'b1;
    end
    rd_req = 1'b0;
    if (!done) chk("rd_timeout", 32'(done), 32'd1);
  endtask

  // Return monitor: every rd_valid must match the oldest outstanding read, on time.
  always @(negedge Clk) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_rd_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.d));
        chk("rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int wcyc;
    int nwr;

    // Reset held with both requests active.
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 21'd7; wr_addr = 21'd9;
    @(posedge Clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_rd_gnt", 32'(rd_gnt), 32'd0);
      chk("rst_wr_gnt", 32'(wr_gnt), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_drop_cnt", 32'(wr_drop_cnt), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      @(posedge Clk); #1;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    Reset = 1'b0;
    tick();

    // Single read of 1234 returning 8'h5A.
    do_write(21'd1234, 8'h5A);
    rd_req = 1'b1; rd_addr = 21'd1234;
    tick();
    chk("t2_rd_gnt", 32'(g_rd), 32'd1);
    rd_req = 1'b0;
    chk("t2_mem_addr", 32'(mem_addr), 32'd1234);
    chk("t2_mem_we", 32'(mem_we), 32'd0);
    chk("t2_valid_n1", 32'(rd_valid), 32'd0);
    tick();
    chk("t2_valid_n2", 32'(rd_valid), 32'd1);
    chk("t2_data_n2", 32'(rd_data), 32'h5A);
    tick();
    chk("t2_valid_n3", 32'(rd_valid), 32'd0);

    // Read stream with a write pending: the write must land on the 16th waiting cycle.
    rd_req = 1'b1; rd_addr = 21'd1234;
    wr_req = 1'b1; wr_addr = 21'd500; wr_data = 8'h77;
    wcyc = -1; nwr = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (g_wr) begin
        nwr++;
        if (wcyc < 0) wcyc = i;
        wr_req = 1'b0;
      end
      if (i != 15) chk("t3_rd_gnt", 32'(g_rd), 32'd1);
    end
    rd_req = 1'b0;
    chk("t3_wr_cycle", 32'(wcyc), 32'd15);
    chk("t3_wr_count", 32'(nwr), 32'd1);
    tick(); tick(); tick();

    // Last in-range address, then the first out-of-range address.
    do_write(21'd307199, 8'h33);
    chk("t4_we_hi", 32'(mem_we), 32'd1);
    chk("t4_addr", 32'(mem_addr), 32'd307199);
    chk("t4_wdata", 32'(mem_wdata), 32'h33);
    tick();
    chk("t4_we_lo", 32'(mem_we), 32'd0);
    do_write(21'd307200, 8'h44);
    chk("t4_drop_gnt", 32'(g_wr), 32'd1);
    chk("t4_drop_we", 32'(mem_we), 32'd0);
    chk("t4_drop_cnt", 32'(wr_drop_cnt), 32'd1);
    chk("t4_addr_hold", 32'(mem_addr), 32'd307199);

    // Alternating random read/write traffic over a small address window.
    for (int k = 0; k < 16; k++) do_write(21'(100 + k), 8'($urandom));
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) do_write(21'(100 + $urandom_range(15, 0)), 8'($urandom));
      else            do_read(21'(100 + $urandom_range(15, 0)));
    end
    tick(); tick(); tick();

    // Reset lands the cycle after a read grant; that read must never return.
    do_read(21'd1234);
    Reset = 1'b1;
    sb.delete();
    tick();
    chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_mem_addr", 32'(mem_addr), 32'd0);
    chk("t6_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("t6_rd_data", 32'(rd_data), 32'd0);
    chk("t6_drop_cnt", 32'(wr_drop_cnt), 32'd0);
    Reset = 1'b0;
    tick(); tick();
    do_read(21'd1234);
    tick();
    chk("t6_post_valid", 32'(rd_valid), 32'd1);
    chk("t6_post_data", 32'(rd_data), 32'h5A);

    for (int i = 0; i < 4; i++) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
